// File: rtl/tdc_sequencer.sv
// tdc_sequencer: runs a burst of 2**N_AVG_LOG2 TDC measurements and presents the sum of the counts.
// Define TDC_SEQ_TIMEOUT_EN to compile in the WAIT-state watchdog; timeout_err is tied low otherwise.
module tdc_sequencer #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned N_AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    output logic                        busy,
    output logic                        start,
    input  logic                        ready,
    input  logic [CNT_W-1:0]            count,
    output logic [CNT_W+N_AVG_LOG2-1:0] result,
    output logic                        result_valid,
    input  logic                        result_ack,
    output logic                        timeout_err
);

    localparam int unsigned ACC_W  = CNT_W + N_AVG_LOG2;
    localparam int unsigned IDX_W  = N_AVG_LOG2 + 1;
    localparam int unsigned N_MEAS = 1 << N_AVG_LOG2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_inc;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] r_sample;
    logic [ACC_W-1:0] r_result;
    logic             r_result_valid;
    logic             r_busy;

`ifdef TDC_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wdog;
    logic            w_wd_expire;
    logic            r_timeout_err;

    assign w_wd_expire = (r_state == ST_WAIT) && !ready && (r_wdog == WD_LAST);
`endif

    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_last    = (w_idx_inc == IDX_W'(N_MEAS));
    assign w_sum     = r_acc + ACC_W'(r_sample);
    assign w_accept  = (r_state == ST_IDLE) && (w_next == ST_START);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start depends on live ready so it never fires into a held ready
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req && !r_result_valid) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (!ready) begin
                    w_start = 1'b1;
                    w_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ready) begin
                    w_next = ST_CAPTURE;
                end
`ifdef TDC_SEQ_TIMEOUT_EN
                else if (w_wd_expire) begin
                    w_next = ST_IDLE;
                end
`endif
            end
            ST_CAPTURE: begin
                w_next = w_last ? ST_DONE : ST_START;
            end
            ST_DONE: begin
                if (result_ack) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: count is latched while ready is high and summed in CAPTURE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx          <= '0;
            r_acc          <= '0;
            r_sample       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= (w_next == ST_DONE);
            r_busy         <= (w_next == ST_START) || (w_next == ST_WAIT) ||
                              (w_next == ST_CAPTURE);
            if (w_accept) begin
                r_idx    <= '0;
                r_acc    <= '0;
                r_result <= '0;
            end
            if ((r_state == ST_WAIT) && ready) begin
                r_sample <= count;
            end
            if (r_state == ST_CAPTURE) begin
                r_acc <= w_sum;
                r_idx <= w_idx_inc;
                if (w_last) begin
                    r_result <= w_sum;
                end
            end
        end
    end

`ifdef TDC_SEQ_TIMEOUT_EN
    // Watchdog restarts on every WAIT entry; the error flag is sticky until the next accepted req
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy         = r_busy;
    assign start        = w_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Scoreboard bench for tdc_sequencer: a TDC controller model answers start pulses from a count queue,
// expected burst sums are queued at request time and checked by an independent output monitor.
module tb_tdc_sequencer;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NAVG    = 2;
    localparam int unsigned N_MEAS  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic              clk;
    logic              rst;
    logic              req;
    logic              busy;
    logic              start;
    logic              ready;
    logic [CNT_W-1:0]  count;
    logic [CNT_W+NAVG-1:0] result;
    logic              result_valid;
    logic              result_ack;
    logic              timeout_err;

    tdc_sequencer #(
        .CNT_W      (CNT_W),
        .N_AVG_LOG2 (NAVG),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .busy         (busy),
        .start        (start),
        .ready        (ready),
        .count        (count),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        int sum;
        int lat;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_q[$];
    exp_t cur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int k_cfg = 3;
    bit stuck_cfg = 1'b0;
    bit ctrl_mute = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TDC controller model: ready returns K cycles after a start pulse, with the next queued count
    int ck;
    int cv;
    initial begin
        ready = 1'b0;
        count = '0;
        forever begin
            @(negedge clk);
            if (start && rst && !ctrl_mute) begin
                ck = (k_cfg > 0) ? k_cfg : int'($urandom_range(1, 6));
                cv = (cnt_q.size() > 0) ? cnt_q.pop_front() : 0;
                repeat (ck) @(posedge clk);
                #1;
                ready = 1'b1;
                count = CNT_W'(cv);
                if (stuck_cfg) repeat (5) @(posedge clk);
                @(posedge clk);
                #1;
                ready = 1'b0;
                count = CNT_W'($urandom);
            end
        end
    end

    // Output monitor: pops an expectation whenever a new result is presented
    bit prev_rv = 1'b0;
    int pulses = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
            pulses  = 0;
        end else begin
            if (start) check("start_while_ready", int'(ready), 0);
            if (!busy && !result_valid) pulses = 0;
            else if (start) pulses++;
            if (result_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("result", int'(result), cur.sum);
                    check("start_pulses", pulses, N_MEAS);
                    check("busy_in_done", int'(busy), 0);
                    if (cur.lat >= 0) check("latency", cyc - cur.cyc, cur.lat);
                end
            end else if (result_valid) begin
                check("result_stable", int'(result), cur.sum);
            end
            prev_rv = result_valid;
        end
    end

    // Called at posedge+1; the req is sampled by the next edge
    task automatic start_burst(input int v0, input int v1, input int v2, input int v3, input int lat);
        exp_t e;
        e.sum = v0 + v1 + v2 + v3;
        e.lat = lat;
        e.cyc = cyc;
        cnt_q.push_back(v0);
        cnt_q.push_back(v1);
        cnt_q.push_back(v2);
        cnt_q.push_back(v3);
        exp_q.push_back(e);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("accepted_busy", int'(busy), 1);
        check("accept_clears_err", int'(timeout_err), 0);
    endtask

    task automatic finish_burst(input bit poke, input int ack_dly);
        int n = 0;
        while (!result_valid) begin
            if (n > 2000) begin
                check("result_wait_expired", 0, 1);
                req = 1'b0;
                return;
            end
            req = (poke && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        req = poke;
        repeat (ack_dly) begin
            @(posedge clk);
            #1;
        end
        result_ack = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        check("rv_after_ack", int'(result_valid), 0);
        check("busy_after_ack", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("req_not_queued", int'(busy), 0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        req = 1'b0;
        result_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(start), 0);
        check("rst_result", int'(result), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_err", int'(timeout_err), 0);

        // Nominal burst, req on the first edge out of reset, K=3
        rst = 1'b1;
        k_cfg = 3;
        start_burst(10, 20, 30, 40, N_MEAS * (3 + 2) + 1);
        finish_burst(1'b1, 2);

        // Full-scale counts must not wrap
        start_burst(255, 255, 255, 255, N_MEAS * (3 + 2) + 1);
        finish_burst(1'b0, 0);

        // Delayed ack with req held during result_valid
        start_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
        finish_burst(1'b1, 20);

        // Ack while idle has no effect
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        check("idle_ack_busy", int'(busy), 0);
        check("idle_ack_rv", int'(result_valid), 0);

        // Ready held high after each capture
        stuck_cfg = 1'b1;
        start_burst(3, 4, 5, 6, -1);
        finish_burst(1'b0, 1);
        stuck_cfg = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Randomized bursts with random ready latency and ack delay
        k_cfg = 0;
        for (int b = 0; b < 8; b++) begin
            start_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
            finish_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
        end

        // Reset during the third WAIT aborts the burst
        k_cfg = 3;
        start_burst(5, 6, 7, 8, -1);
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            if (start) n++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_start", int'(start), 0);
        check("midrst_result", int'(result), 0);
        check("midrst_rv", int'(result_valid), 0);
        check("midrst_err", int'(timeout_err), 0);
        repeat (8) @(posedge clk);
        #1;
        exp_q.delete();
        cnt_q.delete();
        rst = 1'b1;
        start_burst(1, 1, 1, 1, N_MEAS * (3 + 2) + 1);
        finish_burst(1'b0, 0);

`ifdef TDC_SEQ_TIMEOUT_EN
        // Ready never returns: abort after TIMEOUT WAIT cycles
        ctrl_mute = 1'b1;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        n = 0;
        while (busy && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("wd_busy_cycles", n, TIMEOUT + 1);
        check("wd_err_set", int'(timeout_err), 1);
        check("wd_no_rv", int'(result_valid), 0);
        ctrl_mute = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("wd_err_sticky", int'(timeout_err), 1);
        start_burst(2, 4, 6, 8, N_MEAS * (3 + 2) + 1);
        finish_burst(1'b0, 0);
`endif

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global run bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "run bound exceeded");
    end

endmodule

// File: doc/tdc_sequencer.md
TDC_SEQUENCER -- requirements
Module: tdc_sequencer

Interface
REQ-001 The module SHALL expose parameter CNT_W, default 8, as the width of the TDC count word.
REQ-002 The module SHALL expose parameter N_AVG_LOG2, default 2, as log2 of the number of measurements per burst.
REQ-003 The module SHALL expose parameter TIMEOUT, default 64, as the maximum number of WAIT cycles per measurement.
REQ-004 The module SHALL have the following ports, with clk and rst first:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  1  request a measurement burst.
- busy  output  1  burst in progress.
- start  output  1  one-cycle start pulse to the TDC controller.
- ready  input  1  TDC controller measurement complete.
- count  input  CNT_W  TDC count, valid while ready=1.
- result  output  CNT_W+N_AVG_LOG2  sum of the burst's counts.
- result_valid  output  1  result available.
- result_ack  input  1  consumer accepts result.
- timeout_err  output  1  sticky watchdog abort flag.

Function
REQ-005 The FSM SHALL have exactly five states: IDLE, START, WAIT, CAPTURE, DONE.
REQ-006 IDLE SHALL move to START when req=1 and result_valid=0; on that edge it SHALL clear the accumulator, the sample index and timeout_err.
REQ-007 Any req arriving while busy=1 or result_valid=1 SHALL be ignored and SHALL NOT be queued.
REQ-008 START SHALL assert start for exactly one cycle, only while ready=0, and then move to WAIT; while ready=1 it SHALL hold with start=0.
REQ-009 WAIT SHALL move to CAPTURE on the first cycle ready=1 is sampled.
REQ-010 CAPTURE SHALL add the zero-extended count to the accumulator in one cycle and increment the sample index.
REQ-011 CAPTURE SHALL go to DONE when the index reaches 2^N_AVG_LOG2, and to START otherwise.
REQ-012 The accumulator SHALL be CNT_W+N_AVG_LOG2 bits wide and SHALL never overflow.
  - Max burst: 4 x 255 = 1020 fits 10 bits.
REQ-013 In DONE, result SHALL equal the accumulator and result_valid SHALL be 1 and stable until result_ack=1 is sampled.
REQ-014 On the edge that samples result_ack=1, the block SHALL go to IDLE and result_valid SHALL be 0 on the following cycle; result_ack outside DONE SHALL be ignored.
REQ-015 busy SHALL be 1 in START, WAIT and CAPTURE, and 0 in IDLE and DONE.
REQ-016 Latency from accepted req to result_valid, with ready returning K cycles after start, SHALL be 2^N_AVG_LOG2 x (K+2) + 1 cycles.

Reset
REQ-017 While rst=0 at a clock edge, the FSM SHALL go to IDLE and busy, start, result, result_valid and timeout_err SHALL all become 0; the accumulator and counters SHALL clear.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no partial result presented.
REQ-019 The first req SHALL be accepted on the first edge after rst returns to 1.

Configuration
REQ-020 Macro TDC_SEQ_TIMEOUT_EN SHALL compile the WAIT watchdog in or out.
  - Defined: a counter SHALL count WAIT cycles. If ready is still 0 after TIMEOUT cycles, the FSM SHALL go to IDLE, timeout_err SHALL be set, busy SHALL drop, and no result_valid SHALL be produced. timeout_err SHALL stay set until the next accepted req or reset.
  - Undefined: WAIT SHALL persist indefinitely and timeout_err SHALL be tied to 0.
  - The watchdog counter SHALL restart at each entry to WAIT.

Verification (CNT_W=8, N_AVG_LOG2=2, TIMEOUT=64)
REQ-021 Nominal burst: 4 measurements, ready after 3 cycles with count=10,20,30,40 -> exactly 4 start pulses, result=100, result_valid held until ack, then busy=0.
REQ-022 Maximum count: count=255 on all 4 measurements -> result=1020 with no wrap.
REQ-023 Ready held high: ready stuck 1 after a capture for 5 cycles -> no start pulse until ready=0, then exactly one pulse.
REQ-024 Back-pressure and ack edge cases:
  - req during busy and during result_valid -> ignored.
  - result_ack delayed 20 cycles -> result stable throughout.
  - ack in IDLE -> no effect.
REQ-025 Timeout (macro defined): ready never rises -> abort after 64 WAIT cycles, timeout_err=1, no result_valid; the next req clears timeout_err.
REQ-026 Mid-burst reset: rst=0 during the 3rd WAIT -> all outputs 0 next edge; a new burst with counts 1,1,1,1 -> result=4.
